// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - programmable-rate LED animation engine (shift, rotate, bounce, count)
module led_pattern_engine #(
    parameter int NUM_LEDS    = 4,
    parameter int TICK_CYCLES = 16777216,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick,
    output logic [1:0]          active_mode
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [CNT_WIDTH-1:0] TICK_LAST = CNT_WIDTH'(TICK_CYCLES - 1);

    logic [CNT_WIDTH-1:0] prescaler;
    logic [CNT_WIDTH-1:0] prescaler_next;
    logic [NUM_LEDS-1:0]  leds_next;
    logic [1:0]           active_mode_next;
    dir_t                 dir;
    dir_t                 dir_next;

    function automatic logic [NUM_LEDS-1:0] seed(input logic [1:0] m);
        logic [NUM_LEDS-1:0] s;
        s = '0;
        case (mode_t'(m))
            MODE_SHIFT: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    s[i] = ((i % 2) == 0);
                end
            end
            MODE_ROTATE, MODE_BOUNCE: s[0] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    assign tick = enable && (prescaler == TICK_LAST);

    always_comb begin
        prescaler_next   = prescaler;
        leds_next        = leds;
        dir_next         = dir;
        active_mode_next = active_mode;

        if (enable) begin
            prescaler_next = tick ? '0 : prescaler + CNT_WIDTH'(1);
        end

        if (tick) begin
            if (mode != active_mode) begin
                // A mode switch consumes the tick: reload the seed, no step.
                active_mode_next = mode;
                leds_next        = seed(mode);
                dir_next         = DIR_UP;
            end else begin
                case (mode_t'(active_mode))
                    MODE_SHIFT: begin
                        leds_next    = leds << 1;
                        leds_next[0] = ~leds[0];
                    end
                    MODE_ROTATE: begin
                        leds_next = (leds << 1) | (leds >> (NUM_LEDS - 1));
                    end
                    MODE_BOUNCE: begin
                        if (NUM_LEDS == 1) begin
                            leds_next = leds;
                        end else if (dir == DIR_UP) begin
                            leds_next = leds << 1;
                            if (leds_next[NUM_LEDS-1]) dir_next = DIR_DOWN;
                        end else begin
                            leds_next = leds >> 1;
                            if (leds_next[0]) dir_next = DIR_UP;
                        end
                    end
                    default: begin
                        leds_next = leds + NUM_LEDS'(1);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            leds        <= seed(2'd0);
            dir         <= DIR_UP;
            active_mode <= 2'd0;
        end else begin
            prescaler   <= prescaler_next;
            leds        <= leds_next;
            dir         <= dir_next;
            active_mode <= active_mode_next;
        end
    end

endmodule
